peripheral_msi_master_port_bb: RTL and testbench
================================================

Name: peripheral_msi_master_port_bb

Overview:
Upstream neighbour of the MSI slave port, with one instance per AHB master. It decodes the master's address to one of SLAVES slave ports and drives that port's per-master request bus. When the target port has not granted this master, it buffers and replays the address phase. It returns HRDATA/HREADY/HRESP from the slave port serving the data phase and reports can_switch so the slave-port arbiter knows when it may re-grant.

Parameters:
PLEN, 64, address width
XLEN, 64, data width
SLAVES, 5, number of slave ports reachable from this master

Ports:
HRESETn  input  1  asynchronous active-low reset
HCLK  input  1  clock
mst_HSEL  input  1  master select
mst_HADDR  input  PLEN  master address
mst_HWDATA  input  XLEN  master write data
mst_HRDATA  output  XLEN  read data to master
mst_HWRITE  input  1  write
mst_HSIZE  input  3  size
mst_HBURST  input  3  burst
mst_HPROT  input  4  protection
mst_HTRANS  input  2  transfer type
mst_HMASTLOCK  input  1  locked
mst_HREADY  input  1  bus HREADY
mst_HREADYOUT  output  1  ready to master
mst_HRESP  output  1  response to master
slv_addr_base  input  [SLAVES][PLEN]  per-slave base address
slv_addr_mask  input  [SLAVES][PLEN]  per-slave address mask
slvHSEL  output  SLAVES  one-hot select toward slave ports
slvHADDR  output  PLEN  address toward slave ports
slvHWDATA  output  XLEN  write data (equals mst_HWDATA)
slvHRDATA  input  [SLAVES][XLEN]  read data from each slave port
slvHWRITE  output  1  write
slvHSIZE  output  3  size
slvHBURST  output  3  burst
slvHPROT  output  4  protection
slvHTRANS  output  2  transfer type
slvHMASTLOCK  output  1  locked
slvHREADY  output  1  HREADY toward slave ports (equals mst_HREADYOUT)
slvHREADYOUT  input  SLAVES  HREADYOUT from each slave port
slvHRESP  input  SLAVES  HRESP from each slave port
granted  input  SLAVES  bit s=1 when slave port s currently grants this master
can_switch  output  1  this master may be switched away from at the slave port

Behaviour:
- Clocking and reset: HCLK only. Async active-low HRESETn. Reset values: state=IDLE, mst_HREADYOUT=1, mst_HRESP=0, mst_HRDATA=0, slvHSEL=0, can_switch=1, buffer cleared.
- Accept condition: an address phase is accepted when mst_HSEL & mst_HREADY & HTRANS is NONSEQ(2) or SEQ(3).
- Decode: slave s hits when (addr & mask[s]) == (base[s] & mask[s]). The lowest index wins on multiple hits. No hit means unmapped.
- Address source: the buffer in WAIT, otherwise the live mst_* signals. slvHSEL[s] = source valid & hit[s]. All other slv* controls mux from the same source.
- FSM states: IDLE, ACCESS, WAIT, ERR1, ERR2.
- IDLE/ACCESS, accepted with granted[hit]=1: forward combinationally (zero added latency). data_slave <= hit; next state ACCESS.
- IDLE/ACCESS, accepted with granted[hit]=0: capture addr/controls/hit into the buffer; next state WAIT.
- ACCESS data phase: mst_HRDATA=slvHRDATA[data_slave], mst_HREADYOUT=slvHREADYOUT[data_slave], mst_HRESP=slvHRESP[data_slave]. Return to IDLE when the phase completes with no new accept.
- WAIT: mst_HREADYOUT=0, mst_HRESP=0. The buffer is driven with HTRANS forced to NONSEQ. When granted[buf_slave] & slvHREADYOUT[buf_slave], the replay is accepted: data_slave <= buf_slave, next state ACCESS. mst_HREADYOUT stays low until that data phase completes.
- Write data: mst_HWDATA stays stable while stalled, so slvHWDATA needs no buffering.
- Unmapped accept: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE. An address phase accepted during ERR2 is processed normally.
- can_switch: 0 when the source is valid and (HTRANS=SEQ or BUSY or HMASTLOCK=1), otherwise 1. It is always 0 in WAIT with a locked buffer.
- Grant withdrawn mid-ACCESS: the data phase completes from data_slave regardless. Any new address is re-evaluated against granted.
- Reset mid-WAIT/ERR: return immediately to the reset values; the buffered transfer is dropped.

Optional Feature:
MSI_DEFAULT_SLAVE_ERR_EN
- Defined: unmapped addresses take the ERR1/ERR2 path as above.
- Undefined: unmapped addresses route to slave SLAVES-1 as the default slave (normal grant/WAIT rules apply), and ERR states never occur.

Test Plan:
- Setup: base[1]=0x1000, mask=0xF000, granted=0b00010. Stimulus: NONSEQ read 0x1004. Required: slvHSEL=0b00010 in the same cycle, and mst_HRDATA=slvHRDATA[1] in the next cycle with HREADYOUT=1.
- Stimulus: granted[1]=0 for 3 cycles, then 1. Required: mst_HREADYOUT=0 for 4 cycles, and the replay has slvHTRANS=2 and slvHADDR=0x1004.
- Stimulus: 4-beat INCR4 write burst. Required: can_switch=0 during SEQ beats and 1 after the final beat, with slvHWDATA matching each beat.
- Stimulus: access to unmapped 0x9000 with the macro defined. Required: HRESP=1 for 2 cycles, HREADYOUT 0 then 1, then IDLE. With the macro undefined, slvHSEL=0b10000.
- Stimulus: HRESETn pulsed low during WAIT. Required: slvHSEL=0, mst_HREADYOUT=1, can_switch=1 asynchronously.
- Stimulus: slvHRESP[1]=1 two-cycle error during ACCESS. Required: propagated unchanged to mst_HRESP/mst_HREADYOUT.

Source files
------------

// File: rtl/peripheral_msi_master_port_bb_if.sv
// Bus bundle between one AHB master and the MSI slave ports it can reach.
// Modport "master" is the port block's view; "slave" is the surrounding fabric/master view.
interface peripheral_msi_master_port_bb_if #(
  parameter int PLEN   = 64,
  parameter int XLEN   = 64,
  parameter int SLAVES = 5
);
  logic              mst_HSEL;
  logic [PLEN-1:0]   mst_HADDR;
  logic [XLEN-1:0]   mst_HWDATA;
  logic [XLEN-1:0]   mst_HRDATA;
  logic              mst_HWRITE;
  logic [2:0]        mst_HSIZE;
  logic [2:0]        mst_HBURST;
  logic [3:0]        mst_HPROT;
  logic [1:0]        mst_HTRANS;
  logic              mst_HMASTLOCK;
  logic              mst_HREADY;
  logic              mst_HREADYOUT;
  logic              mst_HRESP;

  logic [SLAVES-1:0] slvHSEL;
  logic [PLEN-1:0]   slvHADDR;
  logic [XLEN-1:0]   slvHWDATA;
  logic [XLEN-1:0]   slvHRDATA [SLAVES];
  logic              slvHWRITE;
  logic [2:0]        slvHSIZE;
  logic [2:0]        slvHBURST;
  logic [3:0]        slvHPROT;
  logic [1:0]        slvHTRANS;
  logic              slvHMASTLOCK;
  logic              slvHREADY;
  logic [SLAVES-1:0] slvHREADYOUT;
  logic [SLAVES-1:0] slvHRESP;

  modport master (
    input  mst_HSEL, mst_HADDR, mst_HWDATA, mst_HWRITE, mst_HSIZE, mst_HBURST,
           mst_HPROT, mst_HTRANS, mst_HMASTLOCK, mst_HREADY,
    output mst_HRDATA, mst_HREADYOUT, mst_HRESP,
    output slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST,
           slvHPROT, slvHTRANS, slvHMASTLOCK, slvHREADY,
    input  slvHRDATA, slvHREADYOUT, slvHRESP
  );

  modport slave (
    output mst_HSEL, mst_HADDR, mst_HWDATA, mst_HWRITE, mst_HSIZE, mst_HBURST,
           mst_HPROT, mst_HTRANS, mst_HMASTLOCK, mst_HREADY,
    input  mst_HRDATA, mst_HREADYOUT, mst_HRESP,
    input  slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST,
           slvHPROT, slvHTRANS, slvHMASTLOCK, slvHREADY,
    output slvHRDATA, slvHREADYOUT, slvHRESP
  );
endinterface

// File: rtl/peripheral_msi_master_port_bb.sv
// MSI master port: decodes one AHB master onto SLAVES slave ports, replaying stalled address phases.
// MSI_DEFAULT_SLAVE_ERR_EN: unmapped addresses raise a two-cycle ERROR instead of going to slave SLAVES-1.
module peripheral_msi_master_port_bb #(
  parameter int PLEN   = 64,
  parameter int XLEN   = 64,
  parameter int SLAVES = 5
) (
  input  logic                   HRESETn,
  input  logic                   HCLK,
  peripheral_msi_master_port_bb_if.master bus,
  input  logic [PLEN-1:0]        slv_addr_base [SLAVES],
  input  logic [PLEN-1:0]        slv_addr_mask [SLAVES],
  input  logic [SLAVES-1:0]      granted,
  output logic                   can_switch
);
  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [2:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t            state_reg, state_next;
  logic [SW-1:0]     data_slave_reg, data_slave_next;
  logic [PLEN-1:0]   buf_addr_reg, buf_addr_next;
  logic              buf_write_reg, buf_write_next;
  logic [2:0]        buf_size_reg, buf_size_next;
  logic [2:0]        buf_burst_reg, buf_burst_next;
  logic [3:0]        buf_prot_reg, buf_prot_next;
  logic              buf_lock_reg, buf_lock_next;
  logic [SW-1:0]     buf_slave_reg, buf_slave_next;

  logic [SLAVES-1:0] hit_vec;
  logic [SW-1:0]     hit_idx;
  logic              hit_any;
  logic              accept;
  logic              in_wait;
  logic              src_valid;
  logic [SW-1:0]     sel_idx;
  logic              sel_hit;
  logic [XLEN-1:0]   rdata_sel;

  genvar gi;
  generate
    for (gi = 0; gi < SLAVES; gi++) begin : g_decode
      assign hit_vec[gi] = ((bus.mst_HADDR & slv_addr_mask[gi]) ==
                            (slv_addr_base[gi] & slv_addr_mask[gi]));
    end
  endgenerate

  // Walk downwards so the lowest matching index is the last one written.
  always_comb begin
    hit_idx = '0;
    hit_any = 1'b0;
    for (int s = SLAVES - 1; s >= 0; s--) begin
      if (hit_vec[s]) begin
        hit_idx = SW'(s);
        hit_any = 1'b1;
      end
    end
`ifndef MSI_DEFAULT_SLAVE_ERR_EN
    if (!hit_any) begin
      hit_idx = SW'(SLAVES - 1);
      hit_any = 1'b1;
    end
`endif
  end

  assign accept    = bus.mst_HSEL & bus.mst_HREADY & bus.mst_HTRANS[1];
  assign in_wait   = (state_reg == ST_WAIT);
  assign src_valid = in_wait | bus.mst_HSEL;
  assign sel_idx   = in_wait ? buf_slave_reg : hit_idx;
  assign sel_hit   = in_wait | hit_any;
  assign rdata_sel = bus.slvHRDATA[data_slave_reg];

  // Selects are gated by reset so the slave ports see nothing the instant reset asserts.
  generate
    for (gi = 0; gi < SLAVES; gi++) begin : g_sel
      assign bus.slvHSEL[gi] = HRESETn & src_valid & sel_hit & (sel_idx == SW'(gi));
    end
  endgenerate

  always_comb begin
    bus.slvHADDR     = bus.mst_HADDR;
    bus.slvHWRITE    = bus.mst_HWRITE;
    bus.slvHSIZE     = bus.mst_HSIZE;
    bus.slvHBURST    = bus.mst_HBURST;
    bus.slvHPROT     = bus.mst_HPROT;
    bus.slvHTRANS    = bus.mst_HTRANS;
    bus.slvHMASTLOCK = bus.mst_HMASTLOCK;
    if (in_wait) begin
      bus.slvHADDR     = buf_addr_reg;
      bus.slvHWRITE    = buf_write_reg;
      bus.slvHSIZE     = buf_size_reg;
      bus.slvHBURST    = buf_burst_reg;
      bus.slvHPROT     = buf_prot_reg;
      bus.slvHTRANS    = TR_NONSEQ;
      bus.slvHMASTLOCK = buf_lock_reg;
    end
  end

  assign bus.slvHWDATA = bus.mst_HWDATA;
  assign bus.slvHREADY = bus.mst_HREADYOUT;

  assign can_switch = ~HRESETn |
                      ~(src_valid & ((bus.slvHTRANS == TR_SEQ) | (bus.slvHTRANS == TR_BUSY) |
                                     bus.slvHMASTLOCK));

  always_comb begin
    state_next        = state_reg;
    data_slave_next   = data_slave_reg;
    buf_addr_next     = buf_addr_reg;
    buf_write_next    = buf_write_reg;
    buf_size_next     = buf_size_reg;
    buf_burst_next    = buf_burst_reg;
    buf_prot_next     = buf_prot_reg;
    buf_lock_next     = buf_lock_reg;
    buf_slave_next    = buf_slave_reg;
    bus.mst_HRDATA    = '0;
    bus.mst_HREADYOUT = 1'b1;
    bus.mst_HRESP     = 1'b0;

    case (state_reg)
      ST_ACCESS: begin
        bus.mst_HRDATA    = rdata_sel;
        bus.mst_HREADYOUT = bus.slvHREADYOUT[data_slave_reg];
        bus.mst_HRESP     = bus.slvHRESP[data_slave_reg];
        if (bus.slvHREADYOUT[data_slave_reg]) state_next = ST_IDLE;
      end
      ST_WAIT: begin
        bus.mst_HREADYOUT = 1'b0;
        if (granted[buf_slave_reg] & bus.slvHREADYOUT[buf_slave_reg]) begin
          data_slave_next = buf_slave_reg;
          state_next      = ST_ACCESS;
        end
      end
      ST_ERR1: begin
        bus.mst_HREADYOUT = 1'b0;
        bus.mst_HRESP     = 1'b1;
        state_next        = ST_ERR2;
      end
      ST_ERR2: begin
        bus.mst_HRESP = 1'b1;
        state_next    = ST_IDLE;
      end
      default: ;
    endcase

    // A new address phase overrides the plain end-of-phase transitions above.
    if (accept && (state_reg == ST_IDLE || state_reg == ST_ACCESS || state_reg == ST_ERR2)) begin
      if (!hit_any) begin
        state_next = ST_ERR1;
      end else if (granted[hit_idx]) begin
        data_slave_next = hit_idx;
        state_next      = ST_ACCESS;
      end else begin
        buf_addr_next  = bus.mst_HADDR;
        buf_write_next = bus.mst_HWRITE;
        buf_size_next  = bus.mst_HSIZE;
        buf_burst_next = bus.mst_HBURST;
        buf_prot_next  = bus.mst_HPROT;
        buf_lock_next  = bus.mst_HMASTLOCK;
        buf_slave_next = hit_idx;
        state_next     = ST_WAIT;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg      <= ST_IDLE;
      data_slave_reg <= '0;
      buf_addr_reg   <= '0;
      buf_write_reg  <= 1'b0;
      buf_size_reg   <= '0;
      buf_burst_reg  <= '0;
      buf_prot_reg   <= '0;
      buf_lock_reg   <= 1'b0;
      buf_slave_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      data_slave_reg <= data_slave_next;
      buf_addr_reg   <= buf_addr_next;
      buf_write_reg  <= buf_write_next;
      buf_size_reg   <= buf_size_next;
      buf_burst_reg  <= buf_burst_next;
      buf_prot_reg   <= buf_prot_next;
      buf_lock_reg   <= buf_lock_next;
      buf_slave_reg  <= buf_slave_next;
    end
  end
endmodule

// File: tb/tb_peripheral_msi_master_port_bb.sv
// Directed bench for peripheral_msi_master_port_bb: forwarding, replay, bursts, errors, reset.
// Unmapped-address expectations follow MSI_DEFAULT_SLAVE_ERR_EN when it is defined.
module tb_peripheral_msi_master_port_bb;
  localparam int PLEN   = 64;
  localparam int XLEN   = 64;
  localparam int SLAVES = 5;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [63:0] RD1 = 64'hDA7A_0000_0000_0001;
  localparam logic [63:0] RD4 = 64'hDA7A_0000_0000_0004;

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic [PLEN-1:0]   slv_addr_base [SLAVES];
  logic [PLEN-1:0]   slv_addr_mask [SLAVES];
  logic [SLAVES-1:0] granted;
  logic              can_switch;
  int                checks = 0;
  int                errors = 0;
  int                lowcnt;
  logic [63:0]       bwd [4];
  logic [4:0]        cs_exp;

  peripheral_msi_master_port_bb_if #(.PLEN(PLEN), .XLEN(XLEN), .SLAVES(SLAVES)) bus ();

  peripheral_msi_master_port_bb #(.PLEN(PLEN), .XLEN(XLEN), .SLAVES(SLAVES)) dut (
    .HRESETn       (HRESETn),
    .HCLK          (HCLK),
    .bus           (bus.master),
    .slv_addr_base (slv_addr_base),
    .slv_addr_mask (slv_addr_mask),
    .granted       (granted),
    .can_switch    (can_switch)
  );

  assign bus.mst_HREADY = bus.mst_HREADYOUT;

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic [63:0] addr,
                       input logic wr, input logic [2:0] burst, input logic lock,
                       input logic [63:0] wdata);
    bus.mst_HSEL      = sel;
    bus.mst_HTRANS    = trans;
    bus.mst_HADDR     = addr;
    bus.mst_HWRITE    = wr;
    bus.mst_HBURST    = burst;
    bus.mst_HMASTLOCK = lock;
    bus.mst_HWDATA    = wdata;
  endtask

  task automatic mid();
    @(negedge HCLK);
  endtask

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    drive(1'b0, TR_IDLE, 64'h0, 1'b0, 3'd0, 1'b0, 64'h0);
    bus.mst_HSIZE  = 3'd3;
    bus.mst_HPROT  = 4'h3;
    bus.slvHREADYOUT = '1;
    bus.slvHRESP     = '0;
    granted          = '0;
    for (int s = 0; s < SLAVES; s++) begin
      bus.slvHRDATA[s] = 64'hDA7A_0000_0000_0000 | 64'(s);
      slv_addr_base[s] = 64'(s) << 12;
      slv_addr_mask[s] = 64'hF000;
    end
    bwd[0] = 64'h1111_0000_AAAA_0001;
    bwd[1] = 64'h2222_0000_BBBB_0002;
    bwd[2] = 64'h3333_0000_CCCC_0003;
    bwd[3] = 64'h4444_0000_DDDD_0004;

    // Reset values
    repeat (2) nxt();
    mid();
    $display("txn reset: checking reset values");
    chk("rst_hreadyout", 64'(bus.mst_HREADYOUT), 64'd1);
    chk("rst_hresp", 64'(bus.mst_HRESP), 64'd0);
    chk("rst_hrdata", bus.mst_HRDATA, 64'd0);
    chk("rst_slvhsel", 64'(bus.slvHSEL), 64'd0);
    chk("rst_can_switch", 64'(can_switch), 64'd1);
    nxt();
    HRESETn = 1'b1;

    // Granted read forwards in the same cycle, data one cycle later
    nxt();
    granted = 5'b00010;
    drive(1'b1, TR_NONSEQ, 64'h1004, 1'b0, 3'd0, 1'b0, 64'h0);
    $display("txn read 0x1004 granted");
    mid();
    chk("t1_slvhsel", 64'(bus.slvHSEL), 64'b00010);
    chk("t1_slvhtrans", 64'(bus.slvHTRANS), 64'd2);
    chk("t1_slvhaddr", bus.slvHADDR, 64'h1004);
    chk("t1_can_switch", 64'(can_switch), 64'd1);
    nxt();
    drive(1'b0, TR_IDLE, 64'h0, 1'b0, 3'd0, 1'b0, 64'h0);
    mid();
    chk("t1_hrdata", bus.mst_HRDATA, RD1);
    chk("t1_hreadyout", 64'(bus.mst_HREADYOUT), 64'd1);
    nxt();
    mid();
    chk("t1_idle_hrdata", bus.mst_HRDATA, 64'd0);

    // Not granted: buffer, stall, replay as NONSEQ
    nxt();
    granted = 5'b00000;
    drive(1'b1, TR_NONSEQ, 64'h1004, 1'b0, 3'd0, 1'b0, 64'h0);
    $display("txn read 0x1004 not granted -> replay");
    mid();
    chk("t2_req_slvhsel", 64'(bus.slvHSEL), 64'b00010);
    nxt();
    drive(1'b0, TR_IDLE, 64'h0, 1'b0, 3'd0, 1'b0, 64'h0);
    lowcnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) granted = 5'b00010;
      mid();
      if (bus.mst_HREADYOUT == 1'b0) lowcnt++;
      chk("t2_wait_slvhtrans", 64'(bus.slvHTRANS), 64'd2);
      chk("t2_wait_slvhaddr", bus.slvHADDR, 64'h1004);
      nxt();
    end
    mid();
    if (bus.mst_HREADYOUT == 1'b0) lowcnt++;
    chk("t2_lowcnt", 64'(lowcnt), 64'd4);
    chk("t2_hrdata", bus.mst_HRDATA, RD1);

    // INCR4 write burst
    nxt();
    $display("txn INCR4 write burst at 0x1000");
    cs_exp = 5'b10001;
    for (int b = 0; b < 5; b++) begin
      drive(1'b1, (b == 0) ? TR_NONSEQ : ((b < 4) ? TR_SEQ : TR_IDLE), 64'h1000 + 64'(8 * b),
            1'b1, 3'd3, 1'b0, (b == 0) ? 64'h0 : bwd[b-1]);
      mid();
      chk("t3_can_switch", 64'(can_switch), 64'(cs_exp[b]));
      if (b > 0) begin
        chk("t3_slvhwdata", bus.slvHWDATA, bwd[b-1]);
        chk("t3_hreadyout", 64'(bus.mst_HREADYOUT), 64'd1);
      end
      nxt();
    end
    drive(1'b0, TR_IDLE, 64'h0, 1'b0, 3'd0, 1'b0, 64'h0);

    // Locked transfer stalled in WAIT, then reset asserted asynchronously
    granted = 5'b00000;
    drive(1'b1, TR_NONSEQ, 64'h2000, 1'b0, 3'd0, 1'b1, 64'h0);
    $display("txn locked read 0x2000 not granted, reset during WAIT");
    mid();
    chk("t4_live_lock_cs", 64'(can_switch), 64'd0);
    nxt();
    drive(1'b0, TR_IDLE, 64'h0, 1'b0, 3'd0, 1'b0, 64'h0);
    mid();
    chk("t4_wait_slvhsel", 64'(bus.slvHSEL), 64'b00100);
    chk("t4_wait_hreadyout", 64'(bus.mst_HREADYOUT), 64'd0);
    chk("t4_wait_lock_cs", 64'(can_switch), 64'd0);
    #1 HRESETn = 1'b0;
    #1;
    chk("t5_async_slvhsel", 64'(bus.slvHSEL), 64'd0);
    chk("t5_async_hreadyout", 64'(bus.mst_HREADYOUT), 64'd1);
    chk("t5_async_can_switch", 64'(can_switch), 64'd1);
    nxt();
    granted = 5'b00100;
    HRESETn = 1'b1;
    mid();
    chk("t5_dropped_slvhsel", 64'(bus.slvHSEL), 64'd0);
    chk("t5_idle_hreadyout", 64'(bus.mst_HREADYOUT), 64'd1);

    // Unmapped address
    nxt();
    granted = 5'b10000;
    drive(1'b1, TR_NONSEQ, 64'h9000, 1'b0, 3'd0, 1'b0, 64'h0);
    $display("txn read unmapped 0x9000");
`ifdef MSI_DEFAULT_SLAVE_ERR_EN
    mid();
    chk("t6_err_slvhsel", 64'(bus.slvHSEL), 64'd0);
    nxt();
    drive(1'b0, TR_IDLE, 64'h0, 1'b0, 3'd0, 1'b0, 64'h0);
    mid();
    chk("t6_err1_hresp", 64'(bus.mst_HRESP), 64'd1);
    chk("t6_err1_hreadyout", 64'(bus.mst_HREADYOUT), 64'd0);
    nxt();
    mid();
    chk("t6_err2_hresp", 64'(bus.mst_HRESP), 64'd1);
    chk("t6_err2_hreadyout", 64'(bus.mst_HREADYOUT), 64'd1);
    nxt();
    mid();
    chk("t6_idle_hresp", 64'(bus.mst_HRESP), 64'd0);
    chk("t6_idle_hreadyout", 64'(bus.mst_HREADYOUT), 64'd1);
`else
    mid();
    chk("t6_default_slvhsel", 64'(bus.slvHSEL), 64'b10000);
    nxt();
    drive(1'b0, TR_IDLE, 64'h0, 1'b0, 3'd0, 1'b0, 64'h0);
    mid();
    chk("t6_default_hrdata", bus.mst_HRDATA, RD4);
    chk("t6_default_hresp", 64'(bus.mst_HRESP), 64'd0);
    chk("t6_default_hreadyout", 64'(bus.mst_HREADYOUT), 64'd1);
    nxt();
    mid();
    chk("t6_idle_hrdata", bus.mst_HRDATA, 64'd0);
`endif

    // Two-cycle slave ERROR passes straight through
    nxt();
    granted = 5'b00010;
    drive(1'b1, TR_NONSEQ, 64'h1004, 1'b0, 3'd0, 1'b0, 64'h0);
    $display("txn read 0x1004 with slave error");
    nxt();
    drive(1'b0, TR_IDLE, 64'h0, 1'b0, 3'd0, 1'b0, 64'h0);
    bus.slvHREADYOUT[1] = 1'b0;
    bus.slvHRESP[1]     = 1'b1;
    mid();
    chk("t7_err1_hresp", 64'(bus.mst_HRESP), 64'd1);
    chk("t7_err1_hreadyout", 64'(bus.mst_HREADYOUT), 64'd0);
    nxt();
    bus.slvHREADYOUT[1] = 1'b1;
    mid();
    chk("t7_err2_hresp", 64'(bus.mst_HRESP), 64'd1);
    chk("t7_err2_hreadyout", 64'(bus.mst_HREADYOUT), 64'd1);
    nxt();
    bus.slvHRESP[1] = 1'b0;
    mid();
    chk("t7_idle_hresp", 64'(bus.mst_HRESP), 64'd0);

    // Overlapping windows: lowest index wins; slave 4 now matches everything
    nxt();
    slv_addr_base[4] = 64'h0;
    slv_addr_mask[4] = 64'h0;
    $display("txn decode priority with catch-all slave 4");
    drive(1'b1, TR_IDLE, 64'h1004, 1'b0, 3'd0, 1'b0, 64'h0);
    #1 chk("t8_prio_low", 64'(bus.slvHSEL), 64'b00010);
    drive(1'b1, TR_IDLE, 64'h3008, 1'b0, 3'd0, 1'b0, 64'h0);
    #1 chk("t8_prio_s3", 64'(bus.slvHSEL), 64'b01000);
    drive(1'b1, TR_IDLE, 64'h9000, 1'b0, 3'd0, 1'b0, 64'h0);
    #1 chk("t8_catch_all", 64'(bus.slvHSEL), 64'b10000);
    drive(1'b0, TR_IDLE, 64'h0, 1'b0, 3'd0, 1'b0, 64'h0);
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
